icache_mem_nway: RTL and testbench

- Parametrised N-way set-associative data/tag store for the I-cache. It is the successor to the one-way cachemem array.
- Provides a combinational fetch lookup, a combinational prefetch probe and a registered line fill.
- Keeps per-line valid bits and a per-set tree pseudo-LRU for victim choice, plus a single-cycle flush.
- Sits between the I-cache controller (fill/flush) and the fetch stage / prefetcher (lookups).

---
 rtl/icache_mem_nway_pkg.sv | 32 +++
 rtl/icache_plru.sv | 57 +++++
 rtl/icache_mem_nway.sv | 128 ++++++++++++
 tb/tb_icache_mem_nway.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/icache_mem_nway_pkg.sv
// Shared widths and helpers for the N-way I-cache array.
// Latency: n/a (constants and constant functions only).
// Backpressure: n/a.
`ifndef ICACHE_IDX_W
`define ICACHE_IDX_W 5
`endif
`ifndef ICACHE_TAG_W
`define ICACHE_TAG_W 8
`endif
`ifndef ICACHE_LINE_IN_BITS
`define ICACHE_LINE_IN_BITS 64
`endif
`define ICACHE_CLOG2(x) (((x) > 1) ? $clog2(x) : 1)
`define ICACHE_PLRU_NODES(w) (((w) > 1) ? ((w) - 1) : 1)

package icache_mem_nway_pkg;

    localparam int ICACHE_IDX_W        = `ICACHE_IDX_W;
    localparam int ICACHE_TAG_W        = `ICACHE_TAG_W;
    localparam int ICACHE_LINE_IN_BITS = `ICACHE_LINE_IN_BITS;

    // Width of a way number; at least one bit so direct-mapped still has a port.
    function automatic int way_w(input int ways);
        return `ICACHE_CLOG2(ways);
    endfunction

    // PLRU tree nodes per set; a single unused bit is kept when there is no tree.
    function automatic int plru_nodes(input int ways);
        return `ICACHE_PLRU_NODES(ways);
    endfunction

endpackage

// File: rtl/icache_plru.sv
// Tree pseudo-LRU for one set: victim walk plus read/fill touch and clear.
// Latency: purely combinational; the caller registers next_bits.
// Backpressure: none, every touch request is applied.
module icache_plru #(
    parameter int WAYS  = 2,
    parameter int NODES = 1,
    parameter int WAY_W = 1
) (
    input  logic [NODES-1:0] cur_bits,
    input  logic             rd_touch_en,
    input  logic [WAY_W-1:0] rd_touch_way,
    input  logic             fill_touch_en,
    input  logic [WAY_W-1:0] fill_touch_way,
    input  logic             clear,
    output logic [WAY_W-1:0] victim_way,
    output logic [NODES-1:0] next_bits
);

    localparam int LEVELS = $clog2(WAYS);

    // Set every node on the way's path to point at the other half.
    function automatic logic [NODES-1:0] touch(input logic [NODES-1:0] bits,
                                               input logic [WAY_W-1:0] way);
        logic [NODES-1:0] res;
        int node;
        logic b;
        res  = bits;
        node = 0;
        for (int l = 0; l < LEVELS; l++) begin
            b         = way[LEVELS-1-l];
            res[node] = ~b;
            node      = 2 * node + 1 + int'(b);
        end
        return res;
    endfunction

    // Victim: follow the node bits from the root, each bit picks the half.
    always_comb begin
        int node;
        victim_way = '0;
        node       = 0;
        for (int l = 0; l < LEVELS; l++) begin
            victim_way[LEVELS-1-l] = cur_bits[node];
            node = 2 * node + 1 + int'(cur_bits[node]);
        end
    end

    // Read touch first, then fill touch, so a fill wins on shared nodes.
    always_comb begin
        logic [NODES-1:0] tmp;
        tmp = cur_bits;
        if (rd_touch_en)   tmp = touch(tmp, rd_touch_way);
        if (fill_touch_en) tmp = touch(tmp, fill_touch_way);
        next_bits = clear ? '0 : tmp;
    end

endmodule

// File: rtl/icache_mem_nway.sv
// N-way set-associative I-cache tag/data store with tree PLRU and flush.
// Latency: fetch/prefetch lookups are combinational; fills land at the next edge.
// Backpressure: none; fills and lookups are accepted every cycle, flush drops fills.
module icache_mem_nway
    import icache_mem_nway_pkg::*;
#(
    parameter int WAYS   = 2,
    parameter int IDX_W  = ICACHE_IDX_W,
    parameter int TAG_W  = ICACHE_TAG_W,
    parameter int LINE_W = ICACHE_LINE_IN_BITS,
    localparam int WAY_W = way_w(WAYS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [TAG_W-1:0]  wr_tag_i,
    input  logic [LINE_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    input  logic [TAG_W-1:0]  rd_tag_i,
    input  logic [IDX_W-1:0]  pf_idx_i,
    input  logic [TAG_W-1:0]  pf_tag_i,
    output logic [LINE_W-1:0] rd_data_o,
    output logic              rd_hit_o,
    output logic [WAY_W-1:0]  rd_way_o,
    output logic              pf_hit_o
);

    localparam int SETS  = 1 << IDX_W;
    localparam int NODES = plru_nodes(WAYS);

    logic [WAYS-1:0]   valid_q [SETS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [LINE_W-1:0] data_q  [SETS][WAYS];
    logic [NODES-1:0]  plru_q  [SETS];
    logic [NODES-1:0]  plru_nxt[SETS];
    logic [WAY_W-1:0]  victim  [SETS];

    logic [WAYS-1:0]  rd_hit_vec;
    logic [WAYS-1:0]  pf_hit_vec;
    logic [WAYS-1:0]  wr_match_vec;
    logic [WAY_W-1:0] fill_way;
    logic             fill_en;
    logic             rd_touch;

    assign fill_en  = wr_en_i && !flush_i;
    assign rd_touch = rd_en_i && rd_hit_o && !flush_i;

    // Tag compare for fetch, prefetch and fill; one-hot to binary for the hit way.
    always_comb begin
        rd_data_o    = '0;
        rd_way_o     = '0;
        rd_hit_vec   = '0;
        pf_hit_vec   = '0;
        wr_match_vec = '0;
        for (int w = 0; w < WAYS; w++) begin
            rd_hit_vec[w]   = valid_q[rd_idx_i][w] && (tag_q[rd_idx_i][w] == rd_tag_i);
            pf_hit_vec[w]   = valid_q[pf_idx_i][w] && (tag_q[pf_idx_i][w] == pf_tag_i);
            wr_match_vec[w] = valid_q[wr_idx_i][w] && (tag_q[wr_idx_i][w] == wr_tag_i);
            if (rd_hit_vec[w]) begin
                rd_data_o = rd_data_o | data_q[rd_idx_i][w];
                rd_way_o  = rd_way_o | WAY_W'(w);
            end
        end
        rd_hit_o = |rd_hit_vec;
        pf_hit_o = |pf_hit_vec;
    end

    // Fill target: existing copy of the tag, else lowest invalid way, else PLRU victim.
    always_comb begin
        fill_way = victim[wr_idx_i];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[wr_idx_i][w]) fill_way = WAY_W'(w);
        end
        for (int w = 0; w < WAYS; w++) begin
            if (wr_match_vec[w]) fill_way = WAY_W'(w);
        end
    end

    // One PLRU evaluator per set so read and fill touches in different sets both apply.
    for (genvar s = 0; s < SETS; s++) begin : g_set
        if (WAYS > 1) begin : g_tree
            icache_plru #(
                .WAYS  (WAYS),
                .NODES (NODES),
                .WAY_W (WAY_W)
            ) u_plru (
                .cur_bits       (plru_q[s]),
                .rd_touch_en    (rd_touch && (rd_idx_i == IDX_W'(s))),
                .rd_touch_way   (rd_way_o),
                .fill_touch_en  (fill_en && (wr_idx_i == IDX_W'(s))),
                .fill_touch_way (fill_way),
                .clear          (flush_i),
                .victim_way     (victim[s]),
                .next_bits      (plru_nxt[s])
            );
        end else begin : g_direct
            assign victim[s]   = '0;
            assign plru_nxt[s] = '0;
        end
    end

    // Valid bits and PLRU state: cleared by reset or flush, set by fills.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '{default: '0};
            plru_q  <= '{default: '0};
        end else begin
            plru_q <= plru_nxt;
            if (flush_i) begin
                valid_q <= '{default: '0};
            end else if (wr_en_i) begin
                valid_q[wr_idx_i][fill_way] <= 1'b1;
            end
        end
    end

    // Tag and data arrays are qualified by valid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[wr_idx_i][fill_way]  <= wr_tag_i;
            data_q[wr_idx_i][fill_way] <= wr_data_i;
        end
    end

endmodule

// File: tb/tb_icache_mem_nway.sv
module tb_icache_mem_nway;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        wr_en_i;
    logic [4:0]  wr_idx_i;
    logic [7:0]  wr_tag_i;
    logic [63:0] wr_data_i;
    logic        rd_en_i;
    logic [4:0]  rd_idx_i;
    logic [7:0]  rd_tag_i;
    logic [4:0]  pf_idx_i;
    logic [7:0]  pf_tag_i;

    logic [63:0] d2_data;
    logic        d2_hit;
    logic [0:0]  d2_way;
    logic        d2_pf;
    logic [63:0] d4_data;
    logic        d4_hit;
    logic [1:0]  d4_way;
    logic        d4_pf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    icache_mem_nway #(.WAYS(2), .IDX_W(5), .TAG_W(8), .LINE_W(64)) dut2 (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .wr_en_i(wr_en_i), .wr_idx_i(wr_idx_i), .wr_tag_i(wr_tag_i), .wr_data_i(wr_data_i),
        .rd_en_i(rd_en_i), .rd_idx_i(rd_idx_i), .rd_tag_i(rd_tag_i),
        .pf_idx_i(pf_idx_i), .pf_tag_i(pf_tag_i),
        .rd_data_o(d2_data), .rd_hit_o(d2_hit), .rd_way_o(d2_way), .pf_hit_o(d2_pf)
    );

    icache_mem_nway #(.WAYS(4), .IDX_W(5), .TAG_W(8), .LINE_W(64)) dut4 (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .wr_en_i(wr_en_i), .wr_idx_i(wr_idx_i), .wr_tag_i(wr_tag_i), .wr_data_i(wr_data_i),
        .rd_en_i(rd_en_i), .rd_idx_i(rd_idx_i), .rd_tag_i(rd_tag_i),
        .pf_idx_i(pf_idx_i), .pf_tag_i(pf_tag_i),
        .rd_data_o(d4_data), .rd_hit_o(d4_hit), .rd_way_o(d4_way), .pf_hit_o(d4_pf)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [4:0] idx, input logic [7:0] tag);
        rd_idx_i = idx;
        rd_tag_i = tag;
        pf_idx_i = idx;
        pf_tag_i = tag;
        #1;
    endtask

    task automatic fill(input logic [4:0] idx, input logic [7:0] tag, input logic [63:0] dat);
        wr_en_i   = 1'b1;
        wr_idx_i  = idx;
        wr_tag_i  = tag;
        wr_data_i = dat;
        tick();
        wr_en_i   = 1'b0;
    endtask

    task automatic touch(input logic [4:0] idx, input logic [7:0] tag);
        lookup(idx, tag);
        rd_en_i = 1'b1;
        tick();
        rd_en_i = 1'b0;
    endtask

    initial begin
        rst = 1'b0; flush_i = 1'b0; wr_en_i = 1'b0; rd_en_i = 1'b0;
        wr_idx_i = '0; wr_tag_i = '0; wr_data_i = '0;
        rd_idx_i = '0; rd_tag_i = '0; pf_idx_i = '0; pf_tag_i = '0;
        #22 rst = 1'b1;
        tick();

        // Empty array after reset
        lookup(5'd3, 8'h12);
        chk("rst_hit",  64'(d2_hit),  64'd0);
        chk("rst_data", d2_data,      64'd0);
        chk("rst_way",  64'(d2_way),  64'd0);
        chk("rst_pf",   64'(d2_pf),   64'd0);

        // Two fills into set 3; no bypass in the fill cycle
        wr_en_i = 1'b1; wr_idx_i = 5'd3; wr_tag_i = 8'h12; wr_data_i = 64'hAAAA;
        #1;
        chk("fill_cycle_miss", 64'(d2_hit), 64'd0);
        tick();
        wr_en_i = 1'b0;
        fill(5'd3, 8'h34, 64'hBBBB);
        lookup(5'd3, 8'h12);
        chk("t12_hit",  64'(d2_hit), 64'd1);
        chk("t12_way",  64'(d2_way), 64'd0);
        chk("t12_data", d2_data,     64'hAAAA);
        lookup(5'd3, 8'h34);
        chk("t34_hit",  64'(d2_hit), 64'd1);
        chk("t34_way",  64'(d2_way), 64'd1);
        chk("t34_data", d2_data,     64'hBBBB);
        chk("plru_after_fills", 64'(dut2.plru_q[3]), 64'd0);

        // Touch way 0, then a new tag must evict way 1
        touch(5'd3, 8'h12);
        chk("plru_after_touch", 64'(dut2.plru_q[3]), 64'd1);
        fill(5'd3, 8'h56, 64'hCCCC);
        lookup(5'd3, 8'h34);
        chk("t34_evicted", 64'(d2_hit), 64'd0);
        lookup(5'd3, 8'h12);
        chk("t12_kept", 64'(d2_hit), 64'd1);
        lookup(5'd3, 8'h56);
        chk("t56_hit",  64'(d2_hit), 64'd1);
        chk("t56_way",  64'(d2_way), 64'd1);
        chk("t56_data", d2_data,     64'hCCCC);

        // Refill of a resident tag while PLRU points at way 1: must stay in way 0
        touch(5'd3, 8'h12);
        fill(5'd3, 8'h12, 64'hDDDD);
        lookup(5'd3, 8'h12);
        chk("refill_way",  64'(d2_way), 64'd0);
        chk("refill_data", d2_data,     64'hDDDD);
        chk("refill_pf",   64'(d2_pf),  64'd1);
        lookup(5'd3, 8'h56);
        chk("refill_no_dup", 64'(d2_hit), 64'd1);

        // Flush with a colliding fill; flush-cycle lookup still sees old contents
        flush_i = 1'b1;
        wr_en_i = 1'b1; wr_idx_i = 5'd5; wr_tag_i = 8'h77; wr_data_i = 64'h7777;
        lookup(5'd3, 8'h12);
        chk("flush_cycle_hit", 64'(d2_hit), 64'd1);
        tick();
        flush_i = 1'b0; wr_en_i = 1'b0;
        lookup(5'd5, 8'h77);
        chk("flush_fill_dropped", 64'(d2_hit), 64'd0);
        lookup(5'd3, 8'h12);
        chk("flush_t12", 64'(d2_hit), 64'd0);
        chk("flush_pf",  64'(d2_pf),  64'd0);
        lookup(5'd3, 8'h56);
        chk("flush_t56", 64'(d2_hit), 64'd0);
        chk("flush_plru", 64'(dut2.plru_q[3]), 64'd0);

        // Four-way tree order in set 0
        fill(5'd0, 8'd1, 64'h101);
        fill(5'd0, 8'd2, 64'h102);
        fill(5'd0, 8'd3, 64'h103);
        fill(5'd0, 8'd4, 64'h104);
        touch(5'd0, 8'd1);
        fill(5'd0, 8'd5, 64'h105);
        lookup(5'd0, 8'd3);
        chk("w4_t3_evicted", 64'(d4_hit), 64'd0);
        lookup(5'd0, 8'd5);
        chk("w4_t5_way",  64'(d4_way), 64'd2);
        chk("w4_t5_data", d4_data,     64'h105);
        lookup(5'd0, 8'd4);
        chk("w4_t4_way", 64'(d4_way), 64'd3);
        lookup(5'd0, 8'd1);
        chk("w4_t1_way", 64'(d4_way), 64'd0);

        // Async reset pulse in the middle of a fill
        wr_en_i = 1'b1; wr_idx_i = 5'd0; wr_tag_i = 8'd9; wr_data_i = 64'h109;
        #2 rst = 1'b0;
        #1;
        chk("arst_hit4", 64'(d4_hit), 64'd0);
        chk("arst_pf4",  64'(d4_pf),  64'd0);
        wr_en_i = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        lookup(5'd0, 8'd9);
        chk("arst_fill_lost", 64'(d4_hit), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
